// File: rtl/panorama_pkg.sv
// panorama_pkg
//   Shared types and helpers for the Panorama game datapath timer blocks.
//   main_state_t  : round timer FSM states
//   flash_state_t : LED strobe FSM states
//   band_t        : flash rate band, chosen from the tens digit of the time left
//   secs_to_bcd   : split a 0..99 seconds value into tens/ones BCD digits
//   band_from_tens: map a tens digit onto its flash band
package panorama_pkg;

   localparam int SECS_W = 7;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } main_state_t;

   typedef enum logic {
      F_OFF = 1'b0,
      F_ON  = 1'b1
   } flash_state_t;

   typedef enum logic [1:0] {
      BAND_NONE = 2'd0,
      BAND_SLOW = 2'd1,
      BAND_MID  = 2'd2,
      BAND_FAST = 2'd3
   } band_t;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd2_t;

   function automatic bcd2_t secs_to_bcd(input logic [SECS_W-1:0] secs);
      logic [SECS_W-1:0] t;
      logic [SECS_W-1:0] o;
      bcd2_t             r;
      t      = secs / 7'd10;
      o      = secs % 7'd10;
      r.tens = t[3:0];
      r.ones = o[3:0];
      return r;
   endfunction

   function automatic band_t band_from_tens(input logic [3:0] tens);
      band_t b;
      if (tens >= 4'd3) begin
         b = BAND_NONE;
      end else if (tens == 4'd2) begin
         b = BAND_SLOW;
      end else if (tens == 4'd1) begin
         b = BAND_MID;
      end else begin
         b = BAND_FAST;
      end
      return b;
   endfunction

endpackage

// File: rtl/round_timer_ctrl_flash_sched.sv
// flash_sched
//   LED flash strobe scheduler. The strobe rate rises as the tens digit of
//   the remaining time falls. Everything is held cleared while enable is low.
//   Ports:
//     clk        in   system clock
//     resetn     in   asynchronous active-low reset
//     enable     in   high on cycles where the round timer is and stays in RUN
//     secs_tens  in   BCD tens digit of remaining seconds
//     flash      out  registered strobe level
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   F_OFF | strobe low, waiting for the period counter to wrap
//   F_ON  | strobe high for FLASH_ON_TICKS cycles
module flash_sched
   import panorama_pkg::*;
#(
   parameter int TICKS_PER_SEC  = 50_000_000,
   parameter int FLASH_ON_TICKS = 10_000_000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       enable,
   input  logic [3:0] secs_tens,
   output logic       flash
);

   localparam int PER_W = $clog2(2 * TICKS_PER_SEC);
   localparam int ON_W  = (FLASH_ON_TICKS > 1) ? $clog2(FLASH_ON_TICKS) : 1;

   localparam logic [PER_W-1:0] TC_SLOW = PER_W'(2 * TICKS_PER_SEC - 1);
   localparam logic [PER_W-1:0] TC_MID  = PER_W'(TICKS_PER_SEC - 1);
   localparam logic [PER_W-1:0] TC_FAST = PER_W'(TICKS_PER_SEC / 2 - 1);
   localparam logic [ON_W-1:0]  ON_LOAD = ON_W'(FLASH_ON_TICKS - 1);

   flash_state_t     fstate_q, fstate_d;
   logic [PER_W-1:0] per_cnt_q, per_cnt_d;
   logic [ON_W-1:0]  on_cnt_q, on_cnt_d;
   band_t            band_q, band_d;
   band_t            band;
   logic [PER_W-1:0] per_tc;
   logic             per_wrap;
   logic             flash_q;

   assign band  = band_from_tens(secs_tens);
   assign flash = flash_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fstate_q  <= F_OFF;
         per_cnt_q <= '0;
         on_cnt_q  <= '0;
         band_q    <= BAND_NONE;
         flash_q   <= 1'b0;
      end else begin
         fstate_q  <= fstate_d;
         per_cnt_q <= per_cnt_d;
         on_cnt_q  <= on_cnt_d;
         band_q    <= band_d;
         flash_q   <= (fstate_d == F_ON);
      end
   end

   // The period counter free-runs across both states so a strobe starts
   // exactly once per period; the on-time always fits inside one period.
   always_comb begin
      fstate_d  = fstate_q;
      per_cnt_d = per_cnt_q;
      on_cnt_d  = on_cnt_q;
      band_d    = band_q;
      per_wrap  = 1'b0;
      per_tc    = TC_SLOW;

      case (band)
         BAND_SLOW: per_tc = TC_SLOW;
         BAND_MID:  per_tc = TC_MID;
         BAND_FAST: per_tc = TC_FAST;
         default:   per_tc = TC_SLOW;
      endcase

      if (!enable) begin
         fstate_d  = F_OFF;
         per_cnt_d = '0;
         on_cnt_d  = '0;
         band_d    = BAND_NONE;
      end else begin
         band_d = band;
         // A new band restarts its period from zero; an active strobe is
         // left to finish on its own down-counter.
         if (band == BAND_NONE || band != band_q) begin
            per_cnt_d = '0;
         end else if (per_cnt_q == per_tc) begin
            per_cnt_d = '0;
            per_wrap  = 1'b1;
         end else begin
            per_cnt_d = per_cnt_q + 1'b1;
         end

         case (fstate_q)
            F_OFF: begin
               if (per_wrap) begin
                  fstate_d = F_ON;
                  on_cnt_d = ON_LOAD;
               end
            end
            F_ON: begin
               if (on_cnt_q == '0) begin
                  fstate_d = F_OFF;
               end else begin
                  on_cnt_d = on_cnt_q - 1'b1;
               end
            end
            default: fstate_d = F_OFF;
         endcase
      end
   end

endmodule

// File: rtl/round_timer_ctrl.sv
// round_timer_ctrl
//   Per-round countdown for the Panorama game. Loads a start time, counts
//   whole seconds down, deducts a penalty on each wrong check, reports
//   expiry, drives the LED flash strobe and shows the time as two BCD digits.
//   Ports:
//     clk        in   system clock
//     resetn     in   asynchronous active-low reset
//     start      in   pulse: load START_SECS and run
//     stop       in   pulse: round won, freeze remaining time
//     wrong      in   pulse: wrong answer, deduct PENALTY_SECS
//     running    out  high while in RUN
//     expired    out  one-cycle pulse on entry to EXPIRED
//     tick       out  one-cycle pulse on each natural second decrement
//     flash      out  LED strobe level
//     secs_tens  out  BCD tens of remaining seconds
//     secs_ones  out  BCD ones of remaining seconds
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | not counting; secs holds the last value (time left on win)
//   RUN     | prescaler and seconds counting down, penalties applied
//   EXPIRED | time ran out; secs is 0 until the next start
module round_timer_ctrl
   import panorama_pkg::*;
#(
   parameter int TICKS_PER_SEC  = 50_000_000,
   parameter int START_SECS     = 30,
   parameter int PENALTY_SECS   = 2,
   parameter int FLASH_ON_TICKS = 10_000_000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic       stop,
   input  logic       wrong,
   output logic       running,
   output logic       expired,
   output logic       tick,
   output logic       flash,
   output logic [3:0] secs_tens,
   output logic [3:0] secs_ones
);

   localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

   localparam logic [PRE_W-1:0]  PRE_TC     = PRE_W'(TICKS_PER_SEC - 1);
   localparam logic [SECS_W-1:0] START_LOAD = SECS_W'(START_SECS);
   localparam logic [SECS_W-1:0] PEN_AMT    = SECS_W'(PENALTY_SECS);

   main_state_t       state_q, state_d;
   logic [SECS_W-1:0] secs_q, secs_d;
   logic [PRE_W-1:0]  presc_q, presc_d;
   logic              tick_q, tick_d;
   logic              expired_q, expired_d;
   logic              wrap;
   logic [SECS_W-1:0] pen_now;
   logic [SECS_W:0]   dec;
   logic              flash_en;
   bcd2_t             bcd;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         secs_q    <= '0;
         presc_q   <= '0;
         tick_q    <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         secs_q    <= secs_d;
         presc_q   <= presc_d;
         tick_q    <= tick_d;
         expired_q <= expired_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      secs_d    = secs_q;
      presc_d   = presc_q;
      tick_d    = 1'b0;
      expired_d = 1'b0;
      wrap      = 1'b0;
      pen_now   = '0;
      dec       = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               secs_d  = START_LOAD;
               presc_d = '0;
            end
         end
         RUN: begin
            if (stop) begin
               // Win: leave secs untouched so the display shows time left.
               state_d = IDLE;
            end else if (secs_q == '0) begin
               // secs reached zero on the previous edge; expiry is
               // reported one cycle after the update that emptied it.
               state_d   = EXPIRED;
               expired_d = 1'b1;
            end else begin
               wrap    = (presc_q == PRE_TC);
               presc_d = wrap ? '0 : presc_q + 1'b1;
               pen_now = wrong ? PEN_AMT : '0;
               dec     = {1'b0, pen_now} + {{SECS_W{1'b0}}, wrap};
               secs_d  = ({1'b0, secs_q} > dec) ? secs_q - dec[SECS_W-1:0] : '0;
               tick_d  = wrap;
            end
         end
         EXPIRED: begin
            secs_d = '0;
            if (start) begin
               state_d = RUN;
               secs_d  = START_LOAD;
               presc_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The strobe only advances on edges that stay inside RUN, so leaving RUN
   // drops flash on that same edge.
   assign flash_en = (state_q == RUN) && (state_d == RUN);

   flash_sched #(
      .TICKS_PER_SEC  (TICKS_PER_SEC),
      .FLASH_ON_TICKS (FLASH_ON_TICKS)
   ) u_flash_sched (
      .clk       (clk),
      .resetn    (resetn),
      .enable    (flash_en),
      .secs_tens (secs_tens),
      .flash     (flash)
   );

   assign bcd       = secs_to_bcd(secs_q);
   assign secs_tens = bcd.tens;
   assign secs_ones = bcd.ones;
   assign running   = (state_q == RUN);
   assign tick      = tick_q;
   assign expired   = expired_q;

endmodule
